// File: rtl/fetch_decode_ctrl.sv
// ----------------------------------------------------------------------------
// fetch_decode_ctrl
//
// Pipeline control for the PC and the IF/ID register. Each cycle it decides
// whether the front end advances, holds, or has IF/ID replaced by a NOP. It
// also decides whether a bubble enters ID/EX. It reacts to load-use hazards,
// to redirects resolved in execute, and to instruction-memory wait states.
// Two saturating counters record stall and flush cycles for performance work.
//
// Ports:
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   fd_rs1_i, fd_rs2_i     source register fields of the instruction in IF/ID
//   fd_uses_rs1_i/_rs2_i   the decode instruction actually reads rs1 / rs2
//   de_rd_i                destination register of the instruction in ID/EX
//   de_mem_read_i          the instruction in ID/EX is a load
//   ex_branch_taken_i      execute redirects the PC this cycle
//   imem_valid_i           the fetched instruction word is valid this cycle
//   pc_we_o                PC update enable
//   fd_we_o                IF/ID write enable
//   fd_flush_o             load a NOP into IF/ID (overrides fd_we_o)
//   de_bubble_o            load a bubble into ID/EX
//   state_o                registered state: 0=BOOT, 1=RUN, 2=FLUSH
//   stall_cnt_o            load-use stall cycles (saturating)
//   flush_cnt_o            cycles with fd_flush_o=1 in RUN/FLUSH (saturating)
// ----------------------------------------------------------------------------
module fetch_decode_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       fd_rs1_i,
    input  logic [4:0]       fd_rs2_i,
    input  logic             fd_uses_rs1_i,
    input  logic             fd_uses_rs2_i,
    input  logic [4:0]       de_rd_i,
    input  logic             de_mem_read_i,
    input  logic             ex_branch_taken_i,
    input  logic             imem_valid_i,
    output logic             pc_we_o,
    output logic             fd_we_o,
    output logic             fd_flush_o,
    output logic             de_bubble_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_e;

    // Wrong-path words still to discard after a redirect, not counting the
    // one already sitting in IF/ID.
    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_FLUSH  = (FLUSH_CYCLES > 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [3:0]       flush_left_q, flush_left_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic lu;
    logic stall_inc;
    logic flush_inc;

    // A load in ID/EX writing a register the decode instruction reads.
    // x0 is never a real dependency.
    assign lu = de_mem_read_i && (de_rd_i != 5'd0) &&
                ((fd_uses_rs1_i && (fd_rs1_i == de_rd_i)) ||
                 (fd_uses_rs2_i && (fd_rs2_i == de_rd_i)));

    always_comb begin
        state_d      = state_q;
        flush_left_d = flush_left_q;
        pc_we_o      = 1'b0;
        fd_we_o      = 1'b0;
        fd_flush_o   = 1'b1;
        de_bubble_o  = 1'b1;
        stall_inc    = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end

            ST_FLUSH: begin
                // Hazards are ignored here: everything in front of execute is
                // wrong-path and is being discarded anyway.
                de_bubble_o = 1'b0;
                pc_we_o     = imem_valid_i;
                if (ex_branch_taken_i) begin
                    pc_we_o     = 1'b1;
                    de_bubble_o = 1'b1;
                    if (MULTI_FLUSH) begin
                        flush_left_d = FLUSH_RELOAD;
                    end else begin
                        state_d      = ST_RUN;
                        flush_left_d = 4'd0;
                    end
                end else if (imem_valid_i) begin
                    // Only a delivered word counts as a discarded fetch. The
                    // <= also recovers from a corrupted zero count.
                    if (flush_left_q <= 4'd1) begin
                        state_d      = ST_RUN;
                        flush_left_d = 4'd0;
                    end else begin
                        flush_left_d = flush_left_q - 4'd1;
                    end
                end
            end

            // RUN, and the unused encoding, which behaves exactly like RUN.
            default: begin
                state_d = ST_RUN;
                if (ex_branch_taken_i) begin
                    pc_we_o = 1'b1;
                    if (MULTI_FLUSH) begin
                        state_d      = ST_FLUSH;
                        flush_left_d = FLUSH_RELOAD;
                    end
                end else if (lu) begin
                    fd_flush_o = 1'b0;
                    stall_inc  = 1'b1;
                end else if (!imem_valid_i) begin
                    // Decode proceeds; IF/ID becomes a NOP while fetch waits.
                    de_bubble_o = 1'b0;
                end else begin
                    pc_we_o     = 1'b1;
                    fd_we_o     = 1'b1;
                    fd_flush_o  = 1'b0;
                    de_bubble_o = 1'b0;
                end
            end
        endcase
    end

    assign flush_inc = fd_flush_o && (state_q != ST_BOOT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_BOOT;
            flush_left_q <= 4'd0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            flush_left_q <= flush_left_d;
            if (stall_inc && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
            if (flush_inc && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end
        end
    end

    assign state_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule
